// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, log2 helper, default burst limit.
package uart_tx_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    localparam int unsigned MAX_BURST_DEFAULT = 64;

    // Ceiling log2; callers guarantee value >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter; slave = arbiter side, master = environment side.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 4
);
    localparam int unsigned PortIdxWidth = clog2(NumPorts);

    logic [8*NumPorts-1:0]   ReqData;
    logic [NumPorts-1:0]     ReqValid;
    logic [NumPorts-1:0]     ReqLast;
    logic [NumPorts-1:0]     ReqReady;
    logic [7:0]              TxData;
    logic                    TxValid;
    logic                    TxReady;
    logic                    GrantValid;
    logic [PortIdxWidth-1:0] GrantIdx;

    modport slave (
        input  ReqData, ReqValid, ReqLast, TxReady,
        output ReqReady, TxData, TxValid, GrantValid, GrantIdx
    );

    modport master (
        output ReqData, ReqValid, ReqLast, TxReady,
        input  ReqReady, TxData, TxValid, GrantValid, GrantIdx
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: rotate requests by the pointer, priority-encode, rotate the index back.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NumPorts     = 4,
    localparam int unsigned PortIdxWidth = clog2(NumPorts)
) (
    input  logic [NumPorts-1:0]     req_i,
    input  logic [PortIdxWidth-1:0] pointer_i,
    output logic [PortIdxWidth-1:0] idx_o,
    output logic                    any_o
);
    localparam logic [PortIdxWidth:0] NUM_PORTS_EXT = (PortIdxWidth+1)'(NumPorts);

    logic [NumPorts-1:0]     rotated;
    logic [PortIdxWidth-1:0] first_idx;

    // Modular add of two indices, both already below NumPorts.
    function automatic logic [PortIdxWidth-1:0] wrap_add(input logic [PortIdxWidth:0] a,
                                                          input logic [PortIdxWidth:0] b);
        logic [PortIdxWidth:0] sum;
        sum = a + b;
        if (sum >= NUM_PORTS_EXT) begin
            sum = sum - NUM_PORTS_EXT;
        end
        return sum[PortIdxWidth-1:0];
    endfunction

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rotate
        assign rotated[gi] = req_i[wrap_add((PortIdxWidth+1)'(gi), {1'b0, pointer_i})];
    end

    always_comb begin
        first_idx = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first_idx = PortIdxWidth'(i);
            end
        end
    end

    assign any_o = |rotated;
    assign idx_o = wrap_add({1'b0, first_idx}, {1'b0, pointer_i});

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter among NumPorts byte producers.
// Optional per-grant byte limit enabled by defining UART_ARB_BURST_LIMIT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned MaxBurst = MAX_BURST_DEFAULT
) (
    input logic              Clock,
    input logic              Reset_n,
    uart_tx_arbiter_if.slave arb
);
    localparam int unsigned PortIdxWidth = clog2(NumPorts);
    localparam logic [PortIdxWidth-1:0] LAST_PORT = PortIdxWidth'(NumPorts - 1);

    if (NumPorts < 2 || NumPorts > 8 || MaxBurst < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NumPorts must be 2..8 and MaxBurst at least 1");
    end

    logic [0:0]              state_q, state_d;
    logic [PortIdxWidth-1:0] grant_idx_q, grant_idx_d;
    logic [PortIdxWidth-1:0] pointer_q, pointer_d;
    logic [PortIdxWidth-1:0] pick_idx;
    logic                    pick_any;
    logic                    xfer;
    logic                    release_grant;
    logic [NumPorts-1:0]     req_ready;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    grant_valid;

    uart_tx_arbiter_rr_pick #(
        .NumPorts (NumPorts)
    ) u_rr_pick (
        .req_i     (arb.ReqValid),
        .pointer_i (pointer_q),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    assign xfer = (state_q == ARB_LOCKED) && arb.ReqValid[grant_idx_q] && arb.TxReady;

`ifdef UART_ARB_BURST_LIMIT_EN
    localparam int unsigned BurstWidth = clog2(MaxBurst) + 1;

    logic [BurstWidth-1:0] burst_cnt_q, burst_cnt_d;

    // The transfer that brings the count to MaxBurst ends the grant just like Last.
    assign release_grant = xfer && (arb.ReqLast[grant_idx_q] ||
                                    (burst_cnt_q == BurstWidth'(MaxBurst - 1)));

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_q == ARB_IDLE) begin
            burst_cnt_d = '0;
        end else if (xfer) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign release_grant = xfer && arb.ReqLast[grant_idx_q];
`endif

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        pointer_d   = pointer_q;
        req_ready   = '0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        grant_valid = 1'b0;
        if (state_q == ARB_IDLE) begin
            // Arbitration takes this whole cycle; nothing is forwarded until LOCKED.
            if (pick_any) begin
                grant_idx_d = pick_idx;
                state_d     = ARB_LOCKED;
            end
        end else begin
            tx_data                = arb.ReqData[{grant_idx_q, 3'b000} +: 8];
            tx_valid               = arb.ReqValid[grant_idx_q];
            req_ready[grant_idx_q] = arb.TxReady;
            grant_valid            = 1'b1;
            if (release_grant) begin
                state_d   = ARB_IDLE;
                pointer_d = (grant_idx_q == LAST_PORT) ? '0 : grant_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            pointer_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            pointer_q   <= pointer_d;
        end
    end

    assign arb.ReqReady   = req_ready;
    assign arb.TxData     = tx_data;
    assign arb.TxValid    = tx_valid;
    assign arb.GrantValid = grant_valid;
    assign arb.GrantIdx   = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; burst-limit steps run when UART_ARB_BURST_LIMIT_EN is defined.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int unsigned NP = 4;
`ifdef UART_ARB_BURST_LIMIT_EN
    localparam int unsigned MB = 4;
`else
    localparam int unsigned MB = 64;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter_if #(.NumPorts(NP)) bus ();

    uart_tx_arbiter #(
        .NumPorts (NP),
        .MaxBurst (MB)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .arb     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.TxValid && bus.TxReady) begin
            $display("xfer: port=%0d data=%02h", bus.GrantIdx, bus.TxData);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic [7:0] d, input logic v, input logic l);
        bus.ReqData[p*8 +: 8] = d;
        bus.ReqValid[p]       = v;
        bus.ReqLast[p]        = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ReqData  = '0;
        bus.ReqValid = '0;
        bus.ReqLast  = '0;
        bus.TxReady  = 1'b1;

        // Reset with every port requesting; each port p will send A0+16p then A1+16p (Last).
        for (int p = 0; p < 4; p++) drive(p, 8'hA0 + 8'(16 * p), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_ready", 32'(bus.ReqReady), 32'h0);
            check("rst_txvalid", 32'(bus.TxValid), 32'h0);
            check("rst_grantvalid", 32'(bus.GrantValid), 32'h0);
        end
        rst_n = 1'b1;

        // Round-robin: one arbitration cycle, then two contiguous bytes per port.
        step();
        for (int p = 0; p < 4; p++) begin
            check("rr_grantvalid", 32'(bus.GrantValid), 32'h1);
            check("rr_grantidx", 32'(bus.GrantIdx), 32'(p));
            check("rr_byte0", 32'(bus.TxData), 32'(8'hA0 + 8'(16 * p)));
            check("rr_ready", 32'(bus.ReqReady), 32'(1 << p));
            step();
            drive(p, 8'hA1 + 8'(16 * p), 1'b1, 1'b1);
            #1;
            check("rr_byte1", 32'(bus.TxData), 32'(8'hA1 + 8'(16 * p)));
            check("rr_grantidx_hold", 32'(bus.GrantIdx), 32'(p));
            step();
            drive(p, 8'h00, 1'b0, 1'b0);
            #1;
            check("rr_idle_gv", 32'(bus.GrantValid), 32'h0);
            check("rr_idle_txdata", 32'(bus.TxData), 32'h0);
            if (p < 3) step();
        end

        // Single port 2: 41,42,43 with no bubbles after the grant cycle.
        drive(2, 8'h41, 1'b1, 1'b0);
        #1;
        check("sp_idle_txvalid", 32'(bus.TxValid), 32'h0);
        step();
        check("sp_grantidx", 32'(bus.GrantIdx), 32'h2);
        check("sp_ready", 32'(bus.ReqReady), 32'h4);
        check("sp_byte41", 32'(bus.TxData), 32'h41);
        step();
        drive(2, 8'h42, 1'b1, 1'b0);
        #1;
        check("sp_byte42", 32'(bus.TxData), 32'h42);
        step();
        drive(2, 8'h43, 1'b1, 1'b1);
        #1;
        check("sp_byte43", 32'(bus.TxData), 32'h43);
        check("sp_txvalid43", 32'(bus.TxValid), 32'h1);
        step();
        drive(2, 8'h00, 1'b0, 1'b0);
        #1;
        check("sp_idle_after", 32'(bus.GrantValid), 32'h0);

        // Pointer is 3: port 3 wins over port 0, stalls 10 cycles, then releases with wrap to 0.
        drive(3, 8'h55, 1'b1, 1'b0);
        drive(0, 8'h60, 1'b1, 1'b0);
        step();
        check("wrap_grant3", 32'(bus.GrantIdx), 32'h3);
        check("wrap_byte55", 32'(bus.TxData), 32'h55);
        step();
        drive(3, 8'h55, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < 10; c++) begin
            check("stall_grantidx", 32'(bus.GrantIdx), 32'h3);
            check("stall_gv", 32'(bus.GrantValid), 32'h1);
            check("stall_txvalid", 32'(bus.TxValid), 32'h0);
            check("stall_ready", 32'(bus.ReqReady), 32'h8);
            step();
        end
        drive(3, 8'h56, 1'b1, 1'b1);
        #1;
        check("wrap_byte56", 32'(bus.TxData), 32'h56);
        step();
        drive(3, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h70, 1'b1, 1'b1);
        #1;
        check("wrap_idle", 32'(bus.GrantValid), 32'h0);
        step();
        check("wrap_grant0", 32'(bus.GrantIdx), 32'h0);
        check("wrap_byte60", 32'(bus.TxData), 32'h60);

        // Backpressure on port 0 while port 1 waits.
        bus.TxReady = 1'b0;
        #1;
        check("bp_ready_low", 32'(bus.ReqReady), 32'h0);
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp_ready", 32'(bus.ReqReady), 32'h0);
            check("bp_txdata", 32'(bus.TxData), 32'h60);
            check("bp_grantidx", 32'(bus.GrantIdx), 32'h0);
        end
        bus.TxReady = 1'b1;
        #1;
        check("bp_ready_back", 32'(bus.ReqReady), 32'h1);
        step();
        drive(0, 8'h61, 1'b1, 1'b1);
        #1;
        check("bp_byte61", 32'(bus.TxData), 32'h61);
        check("bp_owner_kept", 32'(bus.GrantIdx), 32'h0);
        step();
        drive(0, 8'h00, 1'b0, 1'b0);
        #1;
        check("bp_idle", 32'(bus.GrantValid), 32'h0);
        step();
        check("bp_grant1", 32'(bus.GrantIdx), 32'h1);
        check("bp_byte70", 32'(bus.TxData), 32'h70);
        check("bp_ready1", 32'(bus.ReqReady), 32'h2);
        step();
        drive(1, 8'h00, 1'b0, 1'b0);
        #1;
        check("bp_final_idle", 32'(bus.GrantValid), 32'h0);

`ifdef UART_ARB_BURST_LIMIT_EN
        // Pointer is 2: port 0 wins, is cut after 4 bytes, port 1 goes, then port 0 resumes.
        drive(0, 8'h80, 1'b1, 1'b0);
        drive(1, 8'h90, 1'b1, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            check("burst_grant0", 32'(bus.GrantIdx), 32'h0);
            check("burst_byte", 32'(bus.TxData), 32'(8'h80 + 8'(k)));
            step();
            drive(0, 8'h81 + 8'(k), 1'b1, 1'b0);
            #1;
        end
        check("burst_cut", 32'(bus.GrantValid), 32'h0);
        step();
        check("burst_grant1", 32'(bus.GrantIdx), 32'h1);
        check("burst_byte90", 32'(bus.TxData), 32'h90);
        step();
        drive(1, 8'h00, 1'b0, 1'b0);
        #1;
        check("burst_idle1", 32'(bus.GrantValid), 32'h0);
        step();
        check("burst_regrant0", 32'(bus.GrantIdx), 32'h0);
        check("burst_byte84", 32'(bus.TxData), 32'h84);
        step();
        drive(0, 8'h85, 1'b1, 1'b1);
        #1;
        check("burst_byte85", 32'(bus.TxData), 32'h85);
        step();
        drive(0, 8'h00, 1'b0, 1'b0);
        #1;
        check("burst_done", 32'(bus.GrantValid), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
